// File: rtl/cl_roi_capture.sv
// Camera Link ROI capture: arms on a PC command, captures N selected frames (or
// runs until stopped) and emits one tagged message per accepted pixel beat.
module cl_roi_capture #(
    parameter int unsigned N_TAP        = 8,
    parameter int unsigned PIXEL_W      = 10,
    parameter int unsigned N_FRAME_SIZE = 20,
    parameter int unsigned N_LINE_SIZE  = 12,
    parameter int unsigned N_CLK_SIZE   = 12,
    parameter int unsigned MSG_W        = 48 + N_TAP * PIXEL_W
) (
    input  logic                       cl_clk,
    input  logic                       reset,
    input  logic                       pc_msg_pending,
    output logic                       pc_msg_ack,
    input  logic [31:0]                pc_msg,
    input  logic                       cl_fval,
    input  logic                       cl_lval,
    input  logic                       cl_dval,
    input  logic [N_TAP*PIXEL_W-1:0]   cl_data,
    input  logic                       fpga_msg_overflow,
    output logic [MSG_W-1:0]           fpga_msg,
    output logic                       fpga_msg_valid,
    output logic                       cl_done,
    output logic [2:0]                 led
);

    localparam int unsigned COUNT_W = 20;
    localparam int unsigned DECIM_W = 8;
    localparam logic [3:0]  OP_ARM      = 4'd1;
    localparam logic [3:0]  OP_ROI_LINE = 4'd2;
    localparam logic [3:0]  OP_ROI_CLK  = 4'd3;
    localparam logic [3:0]  OP_DECIM    = 4'd4;
    localparam logic [3:0]  OP_STOP     = 4'd5;

    typedef enum logic [1:0] {ST_STANDBY, ST_ARMED, ST_CAPTURING} state_t;

    state_t                  state_q, state_d;
    logic                    fval_q, lval_q;
    logic                    ack_q, ack_d;
    logic                    done_q, done_d;
    logic                    valid_q, valid_d;
    logic [MSG_W-1:0]        msg_q, msg_d;
    logic [2:0]              led_q, led_d;
    logic                    ovf_q, ovf_d;
    logic [COUNT_W-1:0]      frames_left_q, frames_left_d;
    logic                    continuous_q, continuous_d;
    logic                    stop_req_q, stop_req_d;
    logic [DECIM_W-1:0]      skip_q, skip_d;
    logic [DECIM_W-1:0]      decim_q, decim_d;
    logic [N_LINE_SIZE-1:0]  roi_line_first_q, roi_line_first_d;
    logic [N_LINE_SIZE-1:0]  roi_line_last_q, roi_line_last_d;
    logic [N_CLK_SIZE-1:0]   roi_clk_first_q, roi_clk_first_d;
    logic [N_CLK_SIZE-1:0]   roi_clk_last_q, roi_clk_last_d;
    logic                    selected_q, selected_d;
    logic [N_FRAME_SIZE-1:0] frame_q, frame_d;
    logic [N_LINE_SIZE-1:0]  line_q, line_d;
    logic                    line_seen_q, line_seen_d;
    logic [N_CLK_SIZE-1:0]   clk_q, clk_d;
    logic                    bof_q, bof_d;
    logic                    bol_q, bol_d;

    logic                    fval_rise, fval_fall, lval_rise, beat;
    logic                    cmd_go, stop_cmd;
    logic [3:0]              opcode;
    logic [N_LINE_SIZE-1:0]  line_cur;
    logic [N_CLK_SIZE-1:0]   clk_cur;
    logic                    bof_cur, bol_cur, sel_cur;
    logic                    arm_start, capturing, roi_ok, accept, end_now;
    logic                    unused_cmd_bits;

    // Edge detection against the registered copies of fval/lval, and command decode
    assign fval_rise       = cl_fval & ~fval_q;
    assign fval_fall       = ~cl_fval & fval_q;
    assign lval_rise       = cl_lval & ~lval_q;
    assign beat            = cl_lval & cl_dval;
    assign cmd_go          = pc_msg_pending & ~ack_q;
    assign opcode          = pc_msg[31:28];
    assign stop_cmd        = cmd_go & (opcode == OP_STOP);
    assign unused_cmd_bits = ^pc_msg[27:24];

    assign pc_msg_ack     = ack_q;
    assign cl_done        = done_q;
    assign fpga_msg_valid = valid_q;
    assign fpga_msg       = msg_q;
    assign led            = led_q;

    // Next-state: counters, configuration, frame selection, message build and FSM
    always_comb begin
        state_d          = state_q;
        ack_d            = cmd_go;
        done_d           = 1'b0;
        valid_d          = 1'b0;
        msg_d            = msg_q;
        frames_left_d    = frames_left_q;
        continuous_d     = continuous_q;
        stop_req_d       = stop_req_q;
        skip_d           = skip_q;
        decim_d          = decim_q;
        roi_line_first_d = roi_line_first_q;
        roi_line_last_d  = roi_line_last_q;
        roi_clk_first_d  = roi_clk_first_q;
        roi_clk_last_d   = roi_clk_last_q;
        frame_d          = frame_q;
        end_now          = 1'b0;
        ovf_d            = ovf_q | (fpga_msg_overflow & valid_q);

        // Position of the current beat; the first lval after fval_rise is line 0
        line_cur = line_q;
        if (fval_rise) begin
            line_cur = '0;
        end else if (lval_rise && line_seen_q && (line_q != '1)) begin
            line_cur = line_q + N_LINE_SIZE'(1);
        end
        line_d      = line_cur;
        line_seen_d = fval_rise ? lval_rise : (line_seen_q | lval_rise);
        clk_cur     = lval_rise ? '0 : clk_q;
        clk_d       = (beat && (clk_cur != '1)) ? clk_cur + N_CLK_SIZE'(1) : clk_cur;
        bof_cur     = bof_q | fval_rise;
        bol_cur     = bol_q | lval_rise;

        if (cmd_go && (state_q == ST_STANDBY)) begin
            case (opcode)
                OP_ARM: begin
                    frames_left_d = pc_msg[19:0];
                    continuous_d  = (pc_msg[19:0] == '0);
                    frame_d       = '0;
                    skip_d        = '0;
                    ovf_d         = 1'b0;
                    stop_req_d    = 1'b0;
                    state_d       = ST_ARMED;
                end
                OP_ROI_LINE: begin
                    roi_line_first_d = N_LINE_SIZE'(pc_msg[23:12]);
                    roi_line_last_d  = N_LINE_SIZE'(pc_msg[11:0]);
                end
                OP_ROI_CLK: begin
                    roi_clk_first_d = N_CLK_SIZE'(pc_msg[23:12]);
                    roi_clk_last_d  = N_CLK_SIZE'(pc_msg[11:0]);
                end
                OP_DECIM: decim_d = pc_msg[7:0];
                default: ;
            endcase
        end

        // Decimation decision is taken at every frame start seen while capturing
        arm_start = (state_q == ST_ARMED) && fval_rise && !stop_cmd;
        sel_cur   = selected_q;
        if (fval_rise && ((state_q == ST_CAPTURING) || arm_start)) begin
            if (skip_q == '0) begin
                sel_cur = 1'b1;
                skip_d  = decim_q;
            end else begin
                sel_cur = 1'b0;
                skip_d  = skip_q - DECIM_W'(1);
            end
        end
        selected_d = sel_cur;

        capturing = (state_q == ST_CAPTURING) || arm_start;
        roi_ok    = (line_cur >= roi_line_first_q) && (line_cur <= roi_line_last_q) &&
                    (clk_cur >= roi_clk_first_q) && (clk_cur <= roi_clk_last_q);
        accept    = capturing && sel_cur && cl_fval && beat && roi_ok;
        valid_d   = accept;
        if (accept) begin
            msg_d = MSG_W'({20'(frame_q), 12'(line_cur), ovf_d, bof_cur, bol_cur, cl_fval,
                            12'(clk_cur), cl_data});
            bof_d = 1'b0;
            bol_d = 1'b0;
        end else begin
            bof_d = bof_cur;
            bol_d = bol_cur;
        end

        case (state_q)
            ST_ARMED: begin
                if (stop_cmd) begin
                    state_d = ST_STANDBY;
                    done_d  = 1'b1;
                end else if (fval_rise) begin
                    state_d = ST_CAPTURING;
                end
            end
            ST_CAPTURING: begin
                if (stop_cmd) stop_req_d = 1'b1;
                if (fval_fall) begin
                    end_now = stop_req_q | stop_cmd;
                    if (selected_q) begin
                        frame_d = frame_q + N_FRAME_SIZE'(1);
                        if (!continuous_q) begin
                            frames_left_d = frames_left_q - COUNT_W'(1);
                            if (frames_left_q == COUNT_W'(1)) end_now = 1'b1;
                        end
                    end
                    if (end_now) begin
                        state_d    = ST_STANDBY;
                        done_d     = 1'b1;
                        stop_req_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase

        led_d = {ovf_d, state_d != ST_STANDBY, valid_d};
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge cl_clk) begin
        if (!reset) begin
            state_q          <= ST_STANDBY;
            fval_q           <= 1'b0;
            lval_q           <= 1'b0;
            ack_q            <= 1'b0;
            done_q           <= 1'b0;
            valid_q          <= 1'b0;
            msg_q            <= '0;
            led_q            <= '0;
            ovf_q            <= 1'b0;
            frames_left_q    <= '0;
            continuous_q     <= 1'b0;
            stop_req_q       <= 1'b0;
            skip_q           <= '0;
            decim_q          <= '0;
            roi_line_first_q <= '0;
            roi_line_last_q  <= '1;
            roi_clk_first_q  <= '0;
            roi_clk_last_q   <= '1;
            selected_q       <= 1'b0;
            frame_q          <= '0;
            line_q           <= '0;
            line_seen_q      <= 1'b0;
            clk_q            <= '0;
            bof_q            <= 1'b0;
            bol_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            fval_q           <= cl_fval;
            lval_q           <= cl_lval;
            ack_q            <= ack_d;
            done_q           <= done_d;
            valid_q          <= valid_d;
            msg_q            <= msg_d;
            led_q            <= led_d;
            ovf_q            <= ovf_d;
            frames_left_q    <= frames_left_d;
            continuous_q     <= continuous_d;
            stop_req_q       <= stop_req_d;
            skip_q           <= skip_d;
            decim_q          <= decim_d;
            roi_line_first_q <= roi_line_first_d;
            roi_line_last_q  <= roi_line_last_d;
            roi_clk_first_q  <= roi_clk_first_d;
            roi_clk_last_q   <= roi_clk_last_d;
            selected_q       <= selected_d;
            frame_q          <= frame_d;
            line_q           <= line_d;
            line_seen_q      <= line_seen_d;
            clk_q            <= clk_d;
            bof_q            <= bof_d;
            bol_q            <= bol_d;
        end
    end

endmodule

// File: tb/tb_cl_roi_capture.sv
// Directed bench for cl_roi_capture: table of capture scenarios plus hand-written
// sequences for STOP, overflow and mid-capture reset.
module tb_cl_roi_capture;

    logic         cl_clk = 1'b0;
    logic         reset;
    logic         pc_msg_pending;
    logic         pc_msg_ack;
    logic [31:0]  pc_msg;
    logic         cl_fval, cl_lval, cl_dval;
    logic [79:0]  cl_data;
    logic         fpga_msg_overflow;
    logic [127:0] fpga_msg;
    logic         fpga_msg_valid;
    logic         cl_done;
    logic [2:0]   led;

    cl_roi_capture dut (
        .cl_clk            (cl_clk),
        .reset             (reset),
        .pc_msg_pending    (pc_msg_pending),
        .pc_msg_ack        (pc_msg_ack),
        .pc_msg            (pc_msg),
        .cl_fval           (cl_fval),
        .cl_lval           (cl_lval),
        .cl_dval           (cl_dval),
        .cl_data           (cl_data),
        .fpga_msg_overflow (fpga_msg_overflow),
        .fpga_msg          (fpga_msg),
        .fpga_msg_valid    (fpga_msg_valid),
        .cl_done           (cl_done),
        .led               (led)
    );

    always #5 cl_clk = ~cl_clk;

    typedef struct {
        int lf, ll, cf, cl, decim, count;
        bit arm_mid;
        int nfr, nl, nb;
        int exp_msgs, done_fr, cam0, cam1, lmin, lmax, cmin, cmax;
    } vec_t;

    vec_t         vecs[6];
    int           checks = 0;
    int           errors = 0;
    logic [127:0] mq[$];
    int           done_cnt = 0;
    int           ack_cnt = 0;

    // Output monitor, sampled on the falling edge
    always @(negedge cl_clk) begin
        if (fpga_msg_valid) mq.push_back(fpga_msg);
        if (cl_done) done_cnt++;
        if (pc_msg_ack) ack_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge cl_clk);
        #1;
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [27:0] arg);
        bit got;
        got = 1'b0;
        pc_msg = {op, arg};
        pc_msg_pending = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (pc_msg_ack) got = 1'b1;
        end
        pc_msg_pending = 1'b0;
        check("cmd_ack", longint'(got), 1);
    endtask

    // Frame: fval lead cycle, nl lines of nb valid beats, optional dval gaps
    task automatic send_frame(input int cf, input int nl, input int nb, input bit gaps);
        cl_fval = 1'b1;
        tick();
        for (int l = 0; l < nl; l++) begin
            for (int b = 0; b < nb; b++) begin
                cl_lval = 1'b1;
                cl_dval = 1'b1;
                cl_data = {8'(cf), 12'(l), 12'(b), 48'h0123_4567_89AB};
                tick();
                if (gaps && (b % 5 == 2)) begin
                    cl_dval = 1'b0;
                    tick();
                end
            end
            cl_lval = 1'b0;
            cl_dval = 1'b0;
            tick();
            tick();
        end
        cl_fval = 1'b0;
        repeat (4) tick();
    endtask

    task automatic scan(input int cmap[8], output int bad, output int lmin, output int lmax,
                        output int cmin, output int cmax);
        logic [127:0] m;
        logic [3:0]   fl;
        int           ft, ln, ck, pft, pln;
        bit           new_fr, new_ln;
        bad = 0; lmin = 1 << 30; lmax = -1; cmin = 1 << 30; cmax = -1; pft = -1; pln = -1;
        for (int k = 0; k < mq.size(); k++) begin
            m  = mq[k];
            ft = int'(m[127:108]);
            ln = int'(m[107:96]);
            fl = m[95:92];
            ck = int'(m[91:80]);
            new_fr = (k == 0) || (ft != pft);
            new_ln = new_fr || (ln != pln);
            if (ft > 7 || cmap[ft] != int'(m[79:72]) || ln != int'(m[71:60]) ||
                ck != int'(m[59:48]) || fl != {1'b0, new_fr, new_ln, 1'b1} ||
                m[47:0] != 48'h0123_4567_89AB) bad++;
            if (ln < lmin) lmin = ln;
            if (ln > lmax) lmax = ln;
            if (ck < cmin) cmin = ck;
            if (ck > cmax) cmax = ck;
            pft = ft;
            pln = ln;
        end
    endtask

    function automatic vec_t mk(input int lf, ll, cf, cl, decim, count, input bit arm_mid,
                                input int nfr, nl, nb, exp_msgs, done_fr, cam0, cam1,
                                lmin, lmax, cmin, cmax);
        vec_t v;
        v.lf = lf; v.ll = ll; v.cf = cf; v.cl = cl; v.decim = decim; v.count = count;
        v.arm_mid = arm_mid; v.nfr = nfr; v.nl = nl; v.nb = nb; v.exp_msgs = exp_msgs;
        v.done_fr = done_fr; v.cam0 = cam0; v.cam1 = cam1;
        v.lmin = lmin; v.lmax = lmax; v.cmin = cmin; v.cmax = cmax;
        return v;
    endfunction

    initial begin
        int done_after[8];
        int cmap[8];
        int bad, lmin, lmax, cmin, cmax, d0, a0, nb_rst, start;

        //             lf  ll     cf  cl     dec cnt mid nfr nl nb  msgs dfr c0 c1  lmin lmax cmin cmax
        vecs[0] = mk(0, 4095, 0, 4095, 0, 2, 0, 3, 4, 16, 128, 1, 0, 1, 0, 3, 0, 15);
        vecs[1] = mk(0, 4095, 0, 4095, 0, 1, 1, 2, 4, 16, 64, 1, 1, -1, 0, 3, 0, 15);
        vecs[2] = mk(1, 2, 4, 7, 0, 1, 0, 2, 4, 16, 8, 0, 0, -1, 1, 2, 4, 7);
        vecs[3] = mk(0, 4095, 0, 4095, 2, 2, 1, 6, 2, 8, 32, 4, 1, 4, 0, 1, 0, 7);
        vecs[4] = mk(3, 1, 0, 4095, 0, 1, 0, 1, 4, 8, 0, 0, -1, -1, 0, 0, 0, 0);
        vecs[5] = mk(3, 3, 14, 15, 0, 1, 0, 1, 4, 16, 2, 0, 0, -1, 3, 3, 14, 15);

        reset = 1'b0; pc_msg_pending = 1'b0; pc_msg = '0;
        cl_fval = 1'b0; cl_lval = 1'b0; cl_dval = 1'b0; cl_data = '0; fpga_msg_overflow = 1'b0;
        repeat (3) tick();
        check("rst_valid", longint'(fpga_msg_valid), 0);
        check("rst_msg_nonzero", longint'(fpga_msg != '0), 0);
        check("rst_done", longint'(cl_done), 0);
        check("rst_ack", longint'(pc_msg_ack), 0);
        check("rst_led", longint'(led), 0);
        reset = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            mq.delete();
            d0 = done_cnt;
            for (int i = 0; i < 8; i++) begin
                done_after[i] = 0;
                cmap[i] = -1;
            end
            cmap[0] = vecs[v].cam0;
            cmap[1] = vecs[v].cam1;
            send_cmd(4'd2, {4'd0, 12'(vecs[v].lf), 12'(vecs[v].ll)});
            send_cmd(4'd3, {4'd0, 12'(vecs[v].cf), 12'(vecs[v].cl)});
            send_cmd(4'd4, {20'd0, 8'(vecs[v].decim)});
            start = 0;
            if (vecs[v].arm_mid) begin
                fork
                    send_frame(0, vecs[v].nl, vecs[v].nb, 1'b0);
                    begin
                        repeat (6) tick();
                        send_cmd(4'd1, {8'd0, 20'(vecs[v].count)});
                    end
                join
                done_after[0] = done_cnt - d0;
                start = 1;
            end else begin
                send_cmd(4'd1, {8'd0, 20'(vecs[v].count)});
            end
            for (int f = start; f < vecs[v].nfr; f++) begin
                send_frame(f, vecs[v].nl, vecs[v].nb, 1'b0);
                done_after[f] = done_cnt - d0;
            end
            repeat (3) tick();
            scan(cmap, bad, lmin, lmax, cmin, cmax);
            check($sformatf("v%0d_msgs", v), mq.size(), vecs[v].exp_msgs);
            check($sformatf("v%0d_done_total", v), done_cnt - d0, 1);
            check($sformatf("v%0d_done_at_frame", v), done_after[vecs[v].done_fr], 1);
            if (vecs[v].done_fr > 0)
                check($sformatf("v%0d_done_early", v), done_after[vecs[v].done_fr - 1], 0);
            check($sformatf("v%0d_fields_bad", v), bad, 0);
            if (vecs[v].exp_msgs > 0) begin
                check($sformatf("v%0d_line_min", v), lmin, vecs[v].lmin);
                check($sformatf("v%0d_line_max", v), lmax, vecs[v].lmax);
                check($sformatf("v%0d_clk_min", v), cmin, vecs[v].cmin);
                check($sformatf("v%0d_clk_max", v), cmax, vecs[v].cmax);
            end
            check($sformatf("v%0d_standby", v), longint'(led[1]), 0);
        end

        // Continuous capture with dval gaps, STOP during the fourth frame
        mq.delete();
        a0 = ack_cnt;
        d0 = done_cnt;
        send_cmd(4'd2, {4'd0, 12'd0, 12'hFFF});
        send_cmd(4'd3, {4'd0, 12'd0, 12'hFFF});
        send_cmd(4'd4, 28'd0);
        send_cmd(4'd7, {8'd0, 20'd3});
        check("ignored_op_state", longint'(led[1]), 0);
        send_cmd(4'd1, 28'd0);
        for (int f = 0; f < 3; f++) send_frame(f, 2, 8, 1'b1);
        check("stop_no_done_yet", done_cnt - d0, 0);
        fork
            send_frame(3, 2, 8, 1'b1);
            begin
                repeat (8) tick();
                send_cmd(4'd5, 28'd0);
            end
        join
        check("stop_done_at_fall", done_cnt - d0, 1);
        send_frame(4, 2, 8, 1'b1);
        repeat (3) tick();
        for (int i = 0; i < 8; i++) cmap[i] = i;
        scan(cmap, bad, lmin, lmax, cmin, cmax);
        check("stop_msgs", mq.size(), 64);
        check("stop_fields_bad", bad, 0);
        check("stop_clk_max", cmax, 7);
        check("stop_done_total", done_cnt - d0, 1);
        check("stop_ack_count", ack_cnt - a0, 6);
        check("stop_standby", longint'(led[1]), 0);

        // STOP while armed ends immediately with a done pulse
        d0 = done_cnt;
        send_cmd(4'd1, 28'd1);
        check("armed_led", longint'(led[1]), 1);
        send_cmd(4'd5, 28'd0);
        tick();
        check("armed_stop_done", done_cnt - d0, 1);
        check("armed_stop_standby", longint'(led[1]), 0);

        // Overflow during a frame, then reset pulled low mid-line
        mq.delete();
        send_cmd(4'd1, 28'd0);
        nb_rst = 0;
        fork
            send_frame(0, 2, 8, 1'b0);
            begin
                fpga_msg_overflow = 1'b1;
                repeat (12) tick();
                fpga_msg_overflow = 1'b0;
                check("ovf_led2", longint'(led[2]), 1);
                check("ovf_msg0_flag3", longint'(mq[0][95]), 0);
                check("ovf_msg1_flag3", longint'(mq[1][95]), 1);
                repeat (3) tick();
                reset = 1'b0;
                tick();
                check("mid_rst_valid", longint'(fpga_msg_valid), 0);
                check("mid_rst_msg_nonzero", longint'(fpga_msg != '0), 0);
                check("mid_rst_done", longint'(cl_done), 0);
                check("mid_rst_ack", longint'(pc_msg_ack), 0);
                check("mid_rst_led", longint'(led), 0);
                nb_rst = mq.size();
                tick();
                reset = 1'b1;
            end
        join
        send_frame(1, 2, 8, 1'b0);
        check("post_rst_silent", mq.size(), nb_rst);

        // Reset restores full ROI, no decimation and a clear overflow flag
        mq.delete();
        send_cmd(4'd1, 28'd1);
        send_frame(2, 2, 8, 1'b0);
        repeat (2) tick();
        for (int i = 0; i < 8; i++) cmap[i] = -1;
        cmap[0] = 2;
        scan(cmap, bad, lmin, lmax, cmin, cmax);
        check("post_rst_msgs", mq.size(), 16);
        check("post_rst_fields_bad", bad, 0);
        check("post_rst_line_max", lmax, 1);
        check("post_rst_led", longint'(led), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
